// File: rtl/lcd_bus_engine_if.sv
// Request/response channel between the LCD request multiplexer and the bus engine.
interface lcd_bus_engine_if;
  logic        we_i;
  logic        wr_i;
  logic        rs_i;
  logic [15:0] data_i;
  logic        id_fm_i;
  logic        read_color_i;
  logic        busy_o;
  logic        write_ok_o;
  logic        write_color_ok_o;
  logic        read_ok_o;
  logic [15:0] rdata_o;
  logic        rdata_valid_o;

  modport master (
    output we_i, wr_i, rs_i, data_i, id_fm_i, read_color_i,
    input  busy_o, write_ok_o, write_color_ok_o, read_ok_o, rdata_o, rdata_valid_o
  );

  modport slave (
    input  we_i, wr_i, rs_i, data_i, id_fm_i, read_color_i,
    output busy_o, write_ok_o, write_color_ok_o, read_ok_o, rdata_o, rdata_valid_o
  );
endinterface

// File: rtl/lcd_bus_engine.sv
// 8080-style 16-bit LCD bus engine: one write or multi-strobe read per request,
// with every pin and status output driven straight from a flop.
module lcd_bus_engine #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2,
  parameter int RD_LOW  = 4,
  parameter int RD_HIGH = 4
) (
  input  logic              pclk,
  input  logic              rst_n,
  lcd_bus_engine_if.slave   req,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic [15:0]       lcd_data_o,
  output logic              lcd_data_oe,
  input  logic [15:0]       lcd_data_i
);

  typedef enum logic [2:0] {IDLE, W_LO, W_HI, R_LO, R_HI, DONE} state_e;

  // Counter is loaded with length-1 and the phase ends when it reaches zero.
  localparam logic [7:0] WL_LD = 8'(WR_LOW  - 1);
  localparam logic [7:0] WH_LD = 8'(WR_HIGH - 1);
  localparam logic [7:0] RL_LD = 8'(RD_LOW  - 1);
  localparam logic [7:0] RH_LD = 8'(RD_HIGH - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  strb_q, strb_d;
  logic        first_q, first_d;
  logic        wr_q, wr_d, rs_q, rs_d;
  logic [15:0] wdata_q, wdata_d;
  logic        phase_end;

  logic        cs_n_q, cs_n_d, rs_o_q, rs_o_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d, oe_q, oe_d;
  logic [15:0] dout_q, dout_d, rdata_q, rdata_d;
  logic        busy_q, busy_d, wok_q, wok_d, wcok_q, wcok_d, rok_q, rok_d, rvld_q, rvld_d;

  assign phase_end = (cnt_q == 8'd0);

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      strb_q  <= '0;
      first_q <= 1'b0;
      wr_q    <= 1'b0;
      rs_q    <= 1'b0;
      wdata_q <= '0;
      cs_n_q  <= 1'b1;
      rs_o_q  <= 1'b0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      wok_q   <= 1'b0;
      wcok_q  <= 1'b0;
      rok_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
      first_q <= first_d;
      wr_q    <= wr_d;
      rs_q    <= rs_d;
      wdata_q <= wdata_d;
      cs_n_q  <= cs_n_d;
      rs_o_q  <= rs_o_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      wok_q   <= wok_d;
      wcok_q  <= wcok_d;
      rok_q   <= rok_d;
      rvld_q  <= rvld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strb_d  = strb_q;
    first_d = first_q;
    wr_d    = wr_q;
    rs_d    = rs_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (req.we_i) begin
        wr_d    = req.wr_i;
        rs_d    = req.rs_i;
        wdata_d = req.data_i;
        strb_d  = (req.id_fm_i && req.read_color_i) ? 2'd3 : 2'd2;
        first_d = 1'b1;
        state_d = req.wr_i ? W_LO : R_LO;
        cnt_d   = req.wr_i ? WL_LD : RL_LD;
      end
      W_LO: if (phase_end) begin
        state_d = W_HI;
        cnt_d   = WH_LD;
      end else cnt_d = cnt_q - 8'd1;
      W_HI: if (phase_end) state_d = DONE;
            else cnt_d = cnt_q - 8'd1;
      R_LO: if (phase_end) begin
        state_d = R_HI;
        cnt_d   = RH_LD;
        strb_d  = strb_q - 2'd1;
        first_d = 1'b0;
      end else cnt_d = cnt_q - 8'd1;
      R_HI: if (phase_end) begin
        if (strb_q != 2'd0) begin
          state_d = R_LO;
          cnt_d   = RL_LD;
        end else state_d = DONE;
      end else cnt_d = cnt_q - 8'd1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins themselves are flops.
  always_comb begin
    cs_n_d  = 1'b1;
    rs_o_d  = 1'b0;
    wr_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    oe_d    = 1'b0;
    dout_d  = '0;
    busy_d  = (state_d != IDLE);
    wok_d   = 1'b0;
    wcok_d  = 1'b0;
    rok_d   = 1'b0;
    rvld_d  = (state_q == R_LO) && phase_end && !first_q;
    rdata_d = rvld_d ? lcd_data_i : rdata_q;
    if (state_d != IDLE) rs_o_d = rs_d;
    case (state_d)
      W_LO: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        oe_d   = 1'b1;
        dout_d = wdata_d;
      end
      W_HI: begin
        cs_n_d = 1'b0;
        oe_d   = 1'b1;
        dout_d = wdata_d;
      end
      R_LO: begin
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      R_HI: cs_n_d = 1'b0;
      DONE: begin
        wok_d  = wr_q;
        wcok_d = wr_q & rs_q;
        rok_d  = ~wr_q;
      end
      default: ;
    endcase
  end

  assign lcd_cs_n             = cs_n_q;
  assign lcd_rs               = rs_o_q;
  assign lcd_wr_n             = wr_n_q;
  assign lcd_rd_n             = rd_n_q;
  assign lcd_data_o           = dout_q;
  assign lcd_data_oe          = oe_q;
  assign req.busy_o           = busy_q;
  assign req.write_ok_o       = wok_q;
  assign req.write_color_ok_o = wcok_q;
  assign req.read_ok_o        = rok_q;
  assign req.rdata_o          = rdata_q;
  assign req.rdata_valid_o    = rvld_q;

endmodule

// File: tb/tb_lcd_bus_engine.sv
// Bench for lcd_bus_engine: per-cycle transaction-timeline model, directed table and random traffic.
module tb_lcd_bus_engine;
  localparam int WL = 2, WH = 2, RL = 4, RH = 4, P = RL + RH;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_oe;
  logic [15:0] lcd_data_o, lcd_data_i;
  int          npass = 0, ntot = 0, cyc = 0;

  lcd_bus_engine_if bus ();

  lcd_bus_engine #(.WR_LOW(WL), .WR_HIGH(WH), .RD_LOW(RL), .RD_HIGH(RH)) dut (
    .pclk(pclk), .rst_n(rst_n), .req(bus),
    .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
    .lcd_data_o(lcd_data_o), .lcd_data_oe(lcd_data_oe), .lcd_data_i(lcd_data_i)
  );

  always #5 pclk = ~pclk;

  // Model: the active transaction is its accept cycle plus its attributes;
  // every output is a function of the offset from that cycle.
  logic        m_act = 1'b0, m_wr = 1'b0, m_rs = 1'b0;
  int          m_a0 = 0, m_n = 2;
  logic [15:0] m_data = '0, m_rdata = '0;
  logic [15:0] m_s [3];
  logic [15:0] nxt_s [3];

  typedef struct {
    logic wr, rs; logic [15:0] data; logic idf, rc;
    logic [15:0] s0, s1, s2;
    int done; logic [15:0] first_rd, last_rd; int nvld; logic wc;
  } vec_t;
  vec_t vt [6];

  function automatic int m_dur();
    return m_wr ? 1 + WL + WH : 1 + m_n * P;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  task automatic check_cycle();
    int k, d, ph, s;
    logic e_cs, e_rs, e_wr, e_rd, e_oe, e_busy, e_wok, e_wcok, e_rok, e_rv;
    logic [15:0] e_do;
    k = cyc - m_a0;
    d = m_dur();
    e_cs = 1; e_rs = 0; e_wr = 1; e_rd = 1; e_oe = 0; e_do = '0;
    e_busy = 0; e_wok = 0; e_wcok = 0; e_rok = 0; e_rv = 0;
    if (m_act && k >= 1 && k <= d) begin
      e_busy = 1;
      e_rs   = m_rs;
      if (k == d) begin
        e_wok  = m_wr;
        e_wcok = m_wr && m_rs;
        e_rok  = !m_wr;
      end else begin
        e_cs = 0;
        if (m_wr) begin
          e_oe = 1;
          e_do = m_data;
          e_wr = (k <= WL) ? 1'b0 : 1'b1;
        end else begin
          ph = (k - 1) % P;
          s  = (k - 1) / P;
          e_rd = (ph < RL) ? 1'b0 : 1'b1;
          e_rv = (ph == RL) && (s >= 1);
        end
      end
    end
    chk1("cs_n", lcd_cs_n, e_cs);
    chk1("rs", lcd_rs, e_rs);
    chk1("wr_n", lcd_wr_n, e_wr);
    chk1("rd_n", lcd_rd_n, e_rd);
    chk1("data_oe", lcd_data_oe, e_oe);
    chk16("data_o", lcd_data_o, e_do);
    chk1("busy", bus.busy_o, e_busy);
    chk1("write_ok", bus.write_ok_o, e_wok);
    chk1("write_color_ok", bus.write_color_ok_o, e_wcok);
    chk1("read_ok", bus.read_ok_o, e_rok);
    chk1("rdata_valid", bus.rdata_valid_o, e_rv);
    chk16("rdata", bus.rdata_o, m_rdata);
  endtask

  // Drive one cycle's inputs, advance one edge, update model, check outputs.
  task automatic step(input logic rst, input logic we, input logic wr, input logic rs,
                      input logic [15:0] d, input logic idf, input logic rc);
    int k, dd;
    logic idle, rd_tx;
    k     = cyc - m_a0;
    dd    = m_dur();
    idle  = !m_act || k > dd;
    rd_tx = !idle && !m_wr && k >= 1 && k < dd;
    rst_n = !rst;
    bus.we_i = we; bus.wr_i = wr; bus.rs_i = rs; bus.data_i = d;
    bus.id_fm_i = idf; bus.read_color_i = rc;
    if (rd_tx) lcd_data_i = m_s[(k - 1) / P];
    else       lcd_data_i = 16'($urandom);
    @(posedge pclk);
    if (rst) begin
      m_act   = 1'b0;
      m_rdata = '0;
    end else begin
      if (rd_tx && ((k - 1) % P) == RL - 1 && ((k - 1) / P) >= 1)
        m_rdata = m_s[(k - 1) / P];
      if (idle && we) begin
        m_act = 1'b1; m_a0 = cyc; m_wr = wr; m_rs = rs; m_data = d;
        m_n = (idf && rc) ? 3 : 2;
        for (int i = 0; i < 3; i++) m_s[i] = nxt_s[i];
      end
    end
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    int done_at, nv, wok_cnt;
    logic [15:0] first_v, wl_mask, wc_mask;
    logic wc_seen;

    vt[0] = '{1'b1, 1'b0, 16'h002C, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5, 16'h0000, 16'h0000, 0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 16'hF800, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5, 16'h0000, 16'h0000, 0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111, 16'h9341, 16'hDEAD, 17, 16'h9341, 16'h9341, 1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'hAAAA, 16'h1234, 16'h5678, 25, 16'h1234, 16'h5678, 2, 1'b0};
    vt[4] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'hBBBB, 16'h4321, 16'h5555, 17, 16'h4321, 16'h4321, 1, 1'b0};
    vt[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hCCCC, 16'h0F0F, 16'h6666, 17, 16'h0F0F, 16'h0F0F, 1, 1'b0};
    for (int i = 0; i < 3; i++) nxt_s[i] = '0;

    // Reset with a pending request: nothing may start.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) idle_step();

    for (int i = 0; i < 6; i++) begin
      nxt_s[0] = vt[i].s0; nxt_s[1] = vt[i].s1; nxt_s[2] = vt[i].s2;
      done_at = -1; nv = 0; first_v = '0; wc_seen = 1'b0;
      step(1'b0, 1'b1, vt[i].wr, vt[i].rs, vt[i].data, vt[i].idf, vt[i].rc);
      for (int c = 1; c <= 40; c++) begin
        if (bus.rdata_valid_o) begin
          if (nv == 0) first_v = bus.rdata_o;
          nv++;
        end
        if (bus.write_color_ok_o) wc_seen = 1'b1;
        if (bus.write_ok_o || bus.read_ok_o) begin
          done_at = c;
          break;
        end
        idle_step();
      end
      chki("vec_done_cycle", done_at, vt[i].done);
      chki("vec_valid_count", nv, vt[i].nvld);
      chk1("vec_color_ok", wc_seen, vt[i].wc);
      if (!vt[i].wr) begin
        chk16("vec_first_rdata", first_v, vt[i].first_rd);
        chk16("vec_last_rdata", bus.rdata_o, vt[i].last_rd);
      end
      idle_step();
    end

    // Back-to-back data writes with we_i held high throughout.
    wl_mask = '0; wc_mask = '0;
    for (int j = 0; j <= 11; j++) begin
      step(1'b0, j <= 10, 1'b1, 1'b1,
           (j == 0) ? 16'hF800 : (j >= 6) ? 16'h07E0 : 16'($urandom), 1'b0, 1'b0);
      if (!lcd_wr_n) wl_mask[j + 1] = 1'b1;
      if (bus.write_color_ok_o) wc_mask[j + 1] = 1'b1;
    end
    chk16("b2b_wr_low_cycles", wl_mask, 16'h0186);
    chk16("b2b_color_ok_cycles", wc_mask, 16'h0820);
    idle_step();

    // Reset lands in cycle 3 of a write: abort with no completion.
    wok_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    idle_step();
    idle_step();
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
    chk1("abort_wr_n", lcd_wr_n, 1'b1);
    chk1("abort_busy", bus.busy_o, 1'b0);
    for (int j = 0; j < 6; j++) begin
      idle_step();
      if (bus.write_ok_o) wok_cnt++;
    end
    chki("abort_no_write_ok", wok_cnt, 0);
    done_at = -1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hA5A5, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      if (bus.write_ok_o) begin
        done_at = c;
        break;
      end
      idle_step();
    end
    chki("after_abort_done_cycle", done_at, 5);
    idle_step();

    // Random traffic against the model, with occasional resets.
    for (int j = 0; j < 1500; j++) begin
      for (int i = 0; i < 3; i++) nxt_s[i] = 16'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
           1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
